// File: rtl/data_array_arbiter_pkg.sv
// Shared types and defaults for the cache data-array port-A arbiter.
package data_arb_pkg;

    typedef enum logic {
        ARB_INIT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

    localparam int DEF_DATA_WIDTH   = 512;
    localparam int DEF_DATA_DEPTH   = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_FILL = 1'b1;

endpackage

// File: rtl/data_array_arbiter_if.sv
// One requester port: request handshake plus its one-cycle read response.
interface data_array_arbiter_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_W     = 4
);
    logic                    valid;
    logic                    ready;
    logic                    write;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;

    modport master (
        output valid, write, addr, wdata, byte_en,
        input  ready, resp_valid, resp_rdata
    );

    modport slave (
        input  valid, write, addr, wdata, byte_en,
        output ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/data_array_arbiter_grant.sv
// Grant select for the two requesters; optional port-0 anti-starvation
// counter enabled by DATA_ARB_FAIR_EN.
module data_arb_grant
    import data_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);

`ifdef DATA_ARB_FAIR_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] r_wait0;
    logic              w_force0;

    assign w_force0 = i_run && i_valid0 && (r_wait0 == WAIT_W'(STARVE_LIMIT));
    assign o_grant1 = i_run && i_valid1 && !w_force0;

    // Counts consecutive denied cycles of a waiting port 0, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait0 <= '0;
        end else if (i_run) begin
            if (!i_valid0 || o_grant0)
                r_wait0 <= '0;
            else if (r_wait0 != WAIT_W'(STARVE_LIMIT))
                r_wait0 <= r_wait0 + 1'b1;
        end
    end
`else
    wire w_unused = &{1'b0, i_clk, i_rst_n};

    assign o_grant1 = i_run && i_valid1;
`endif

    assign o_grant0 = i_run && i_valid0 && !o_grant1;

endmodule

// File: rtl/data_array_arbiter.sv
// Port-A sequencer for the cache data array: zero-fills all lines after reset,
// then arbitrates core/fill requests. Optional fair mode: DATA_ARB_FAIR_EN.
module data_array_arbiter
    import data_arb_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int DATA_DEPTH   = DEF_DATA_DEPTH,
    parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int ADDR_W       = $clog2(DATA_DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    data_array_arbiter_if.slave     req0,
    data_array_arbiter_if.slave     req1,
    output logic                    o_da_read_en,
    output logic [ADDR_W-1:0]       o_da_read_addr,
    output logic                    o_da_write_en,
    output logic [ADDR_W-1:0]       o_da_write_addr,
    output logic [DATA_WIDTH-1:0]   o_da_write_data,
    output logic [DATA_WIDTH/8-1:0] o_da_write_byte_en,
    input  logic [DATA_WIDTH-1:0]   i_da_read_data,
    output logic                    o_init_done
);

    arb_state_e        r_state;
    logic [ADDR_W-1:0] r_init_addr;
    logic              r_init_done;
    logic              r_pend_valid;
    logic              r_pend_port;

    logic                    w_init;
    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_any_grant;
    logic                    w_sel_write;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic [DATA_WIDTH/8-1:0] w_sel_byte_en;

    assign w_init = (r_state == ARB_INIT);

    data_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_run    (!w_init),
        .i_valid0 (req0.valid),
        .i_valid1 (req1.valid),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign req0.ready  = w_grant0;
    assign req1.ready  = w_grant1;
    assign w_any_grant = w_grant0 || w_grant1;

    assign w_sel_write   = w_grant1 ? req1.write   : req0.write;
    assign w_sel_addr    = w_grant1 ? req1.addr    : req0.addr;
    assign w_sel_wdata   = w_grant1 ? req1.wdata   : req0.wdata;
    assign w_sel_byte_en = w_grant1 ? req1.byte_en : req0.byte_en;

    // INIT owns the write port; afterwards the granted request drives it.
    assign o_da_read_en       = w_any_grant && !w_sel_write;
    assign o_da_read_addr     = w_sel_addr;
    assign o_da_write_en      = w_init || (w_any_grant && w_sel_write);
    assign o_da_write_addr    = w_init ? r_init_addr : w_sel_addr;
    assign o_da_write_data    = w_init ? '0 : w_sel_wdata;
    assign o_da_write_byte_en = w_init ? '1 : w_sel_byte_en;

    // Array read data is already registered, so it is routed straight back.
    assign req0.resp_valid = r_pend_valid && (r_pend_port == PORT_CORE);
    assign req1.resp_valid = r_pend_valid && (r_pend_port == PORT_FILL);
    assign req0.resp_rdata = i_da_read_data;
    assign req1.resp_rdata = i_da_read_data;

    assign o_init_done = r_init_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB_INIT;
            r_init_addr  <= '0;
            r_init_done  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_port  <= PORT_CORE;
        end else begin
            case (r_state)
                ARB_INIT: begin
                    r_init_addr <= r_init_addr + 1'b1;
                    if (r_init_addr == ADDR_W'(DATA_DEPTH - 1)) begin
                        r_state     <= ARB_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ARB_RUN: begin
                    r_pend_valid <= w_any_grant && !w_sel_write;
                    r_pend_port  <= w_grant1 ? PORT_FILL : PORT_CORE;
                end
                default: r_state <= ARB_INIT;
            endcase
        end
    end

endmodule
